reg_write_arbiter: RTL and testbench

//  Arbitrates register-bank writes from NREQ requesters (req 0 = SPI host write path, others = on-chip

---
 rtl/reg_write_arbiter_if.sv | 26 ++
 rtl/reg_write_arbiter.sv | 175 +++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Requester and register-bank write bus for reg_write_arbiter.
// The slave modport is the arbiter; the master modport is the environment around it.
interface reg_write_arbiter_if #(
  parameter int unsigned NREQ = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*10-1:0] req_addr;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wr_valid;
  logic [9:0]         wr_addr;
  logic [15:0]        wr_data;
  logic               wr_ready;
  logic               wdog_tripped;
  logic               safe_busy;

  modport master (
    output req_valid, req_addr, req_data, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, wdog_tripped, safe_busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, wdog_tripped, safe_busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin register-write arbiter with host-link watchdog and safe-state write injection.
// Optional SIDE_BUTTON_STOP_EN adds a side_button input whose rising edge also triggers the safe sequence.
module reg_write_arbiter #(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned WDOG_CYCLES = 32'd5000000
) (
  input logic SYS_CLK,
  input logic SYS_RST,
`ifdef SIDE_BUTTON_STOP_EN
  input logic side_button,
`endif
  reg_write_arbiter_if.slave bus
);
  localparam int unsigned PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam bit          WDOG_EN = (WDOG_CYCLES != 0);

  typedef enum logic {ST_ARB, ST_SAFE} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr;
  logic [PW-1:0]   gidx;
  logic            any_req;
  logic [NREQ-1:0] grant_raw;
  logic [NREQ-1:0] grant;
  logic [9:0]      sel_addr;
  logic [15:0]     sel_data;
  logic            free;
  logic [31:0]     wdog_cnt;
  logic            wdog_hit;
  logic            btn_edge;
  logic            enter_safe;
  logic            safe_last;
  logic [2:0]      safe_idx;
  logic [9:0]      safe_addr;
  logic [15:0]     safe_data;
  logic            wr_valid_q;
  logic [9:0]      wr_addr_q;
  logic [15:0]     wr_data_q;
  logic            tripped_q;
  logic            busy_q;

  assign free = !wr_valid_q || bus.wr_ready;

`ifdef SIDE_BUTTON_STOP_EN
  logic btn_prev;
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) btn_prev <= 1'b0;
    else         btn_prev <= side_button;
  end
  assign btn_edge = side_button && !btn_prev;
`else
  assign btn_edge = 1'b0;
`endif

  // Round-robin search starting at rr; grant_raw ignores slot/FSM gating.
  always_comb begin
    any_req   = 1'b0;
    gidx      = '0;
    grant_raw = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any_req && bus.req_valid[PW'((32'(rr) + i) % NREQ)]) begin
        any_req = 1'b1;
        gidx    = PW'((32'(rr) + i) % NREQ);
      end
    end
    if (any_req) grant_raw[gidx] = 1'b1;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_raw[i]) begin
        sel_addr = bus.req_addr[10*i +: 10];
        sel_data = bus.req_data[16*i +: 16];
      end
    end
  end

  always_comb begin
    safe_data = '0;
    case (safe_idx)
      3'd0:    safe_addr = 10'd33;
      3'd1:    safe_addr = 10'd34;
      3'd2:    safe_addr = 10'd35;
      3'd3:    safe_addr = 10'd36;
      default: begin
        safe_addr = 10'd40;
        safe_data = 16'h001F;
      end
    endcase
  end

  // A host accept on the terminal count wins; any trigger suppresses that cycle's grant.
  assign wdog_hit = WDOG_EN && (state == ST_ARB) && !tripped_q
                    && (wdog_cnt == WDOG_CYCLES - 1) && !(free && grant_raw[0]);
  assign safe_last = (safe_idx == 3'd4);

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) state <= ST_ARB;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    enter_safe = 1'b0;
    grant      = '0;
    case (state)
      ST_ARB: begin
        enter_safe = !SYS_RST && (wdog_hit || btn_edge);
        if (enter_safe) state_next = ST_SAFE;
        else if (!SYS_RST && free) grant = grant_raw;
      end
      ST_SAFE: begin
        if (free && safe_last) state_next = ST_ARB;
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      rr         <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      tripped_q  <= 1'b0;
      busy_q     <= 1'b0;
      safe_idx   <= '0;
      wdog_cnt   <= '0;
    end else begin
      if (free) begin
        if (|grant) begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= sel_addr;
          wr_data_q  <= sel_data;
        end else if (state == ST_SAFE) begin
          wr_valid_q <= 1'b1;
          wr_addr_q  <= safe_addr;
          wr_data_q  <= safe_data;
        end else begin
          wr_valid_q <= 1'b0;
        end
      end

      if (|grant) rr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      if (grant[0]) tripped_q <= 1'b0;

      if (enter_safe) begin
        busy_q   <= 1'b1;
        safe_idx <= '0;
      end else if (state == ST_SAFE && free) begin
        if (safe_last) begin
          safe_idx  <= '0;
          busy_q    <= 1'b0;
          tripped_q <= 1'b1;
        end else begin
          safe_idx <= safe_idx + 3'd1;
        end
      end

      if (!WDOG_EN || state == ST_SAFE || tripped_q || grant[0] || enter_safe)
        wdog_cnt <= '0;
      else if (wdog_cnt != WDOG_CYCLES - 1)
        wdog_cnt <= wdog_cnt + 32'd1;
    end
  end

  assign bus.req_ready    = grant;
  assign bus.wr_valid     = wr_valid_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wdog_tripped = tripped_q;
  assign bus.safe_busy    = busy_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a write scoreboard; WDOG_CYCLES overridden to 16.
module tb_reg_write_arbiter;
  localparam int unsigned NREQ = 3;
  localparam int unsigned WDOG = 16;

  logic SYS_CLK = 1'b0;
  logic SYS_RST;
`ifdef SIDE_BUTTON_STOP_EN
  logic side_button;
`endif

  always #5 SYS_CLK = ~SYS_CLK;

  reg_write_arbiter_if #(.NREQ(NREQ)) bus ();

  reg_write_arbiter #(.NREQ(NREQ), .WDOG_CYCLES(WDOG)) dut (
    .SYS_CLK(SYS_CLK),
    .SYS_RST(SYS_RST),
`ifdef SIDE_BUTTON_STOP_EN
    .side_button(side_button),
`endif
    .bus(bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [25:0] sbq[$];
  logic [25:0] hold;
  logic [2:0]  exp_rr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] v);
    bus.req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[10*i +: 10] = 10'($urandom);
      bus.req_data[16*i +: 16] = 16'($urandom);
    end
  endtask

  task automatic push_safe();
    sbq.push_back({10'd33, 16'h0000});
    sbq.push_back({10'd34, 16'h0000});
    sbq.push_back({10'd35, 16'h0000});
    sbq.push_back({10'd36, 16'h0000});
    sbq.push_back({10'd40, 16'h001F});
  endtask

  // Samples 1 time unit after inputs settle, then advances to 1 unit past the next edge.
  task automatic tick(input logic [2:0] exp_rdy, input string tag);
    logic [25:0] e;
    #1;
    check({tag, "_rdy"}, 32'(bus.req_ready), 32'(exp_rdy));
    check({tag, "_onehot"}, 32'($countones(bus.req_ready) <= 1), 32'd1);
    if (bus.wr_valid && bus.wr_ready) begin
      check({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(e[25:16]));
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'(e[15:0]));
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (exp_rdy[i]) sbq.push_back({bus.req_addr[10*i +: 10], bus.req_data[16*i +: 16]});
    @(posedge SYS_CLK);
    #1;
  endtask

  initial begin
    SYS_RST      = 1'b1;
    bus.wr_ready = 1'b1;
`ifdef SIDE_BUTTON_STOP_EN
    side_button  = 1'b0;
`endif
    set_req(3'b111);
    @(posedge SYS_CLK);
    #1;

    tick(3'b000, "rst0");
    tick(3'b000, "rst1");
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_tripped", 32'(bus.wdog_tripped), 32'd0);
    check("rst_busy", 32'(bus.safe_busy), 32'd0);
    SYS_RST = 1'b0;

    exp_rr = 3'b001;
    for (int k = 0; k < 6; k++) begin
      set_req(3'b111);
      if (k == 5) hold = {bus.req_addr[29:20], bus.req_data[47:32]};
      tick(exp_rr, "rr");
      exp_rr = {exp_rr[1:0], exp_rr[2]};
    end

    bus.wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(3'b111);
      tick(3'b000, "stall");
      check("stall_valid", 32'(bus.wr_valid), 32'd1);
      check("stall_hold", 32'({bus.wr_addr, bus.wr_data}), 32'(hold));
    end
    bus.wr_ready = 1'b1;
    set_req(3'b111);
    tick(3'b001, "resume");

    set_req(3'b000);
    for (int k = 0; k < 15; k++) tick(3'b000, "idle_a");
    check("pre_t15_busy", 32'(bus.safe_busy), 32'd0);
    set_req(3'b001);
    tick(3'b001, "req0_t15");
    set_req(3'b000);
    for (int k = 0; k < 15; k++) tick(3'b000, "idle_b");
    check("no_trip_t15", 32'(bus.safe_busy), 32'd0);
    tick(3'b000, "idle_b");
    check("trip_busy", 32'(bus.safe_busy), 32'd1);
    check("trip_tripped", 32'(bus.wdog_tripped), 32'd0);
    push_safe();

    for (int k = 0; k < 5; k++) begin
      set_req(3'b010);
      tick(3'b000, "safe");
      check("safe_busy_seq", 32'(bus.safe_busy), 32'(k < 4));
    end
    check("safe_done_tripped", 32'(bus.wdog_tripped), 32'd1);
    set_req(3'b010);
    tick(3'b010, "post_safe");

    set_req(3'b000);
    for (int k = 0; k < 20; k++) tick(3'b000, "tripped_idle");
    check("no_retrip_busy", 32'(bus.safe_busy), 32'd0);
    check("no_retrip_tripped", 32'(bus.wdog_tripped), 32'd1);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    set_req(3'b001);
    tick(3'b001, "req0_clear");
    check("cleared_tripped", 32'(bus.wdog_tripped), 32'd0);

    set_req(3'b000);
    for (int k = 0; k < 16; k++) tick(3'b000, "idle_c");
    check("retrip_busy", 32'(bus.safe_busy), 32'd1);
    push_safe();
    for (int k = 0; k < 3; k++) tick(3'b000, "safe_mid");
    check("mid_sb_left", 32'(sbq.size()), 32'd3);

    SYS_RST      = 1'b1;
    bus.wr_ready = 1'b0;
    tick(3'b000, "rst_mid");
    sbq.delete();
    SYS_RST      = 1'b0;
    bus.wr_ready = 1'b1;
    check("rst_mid_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.safe_busy), 32'd0);
    check("rst_mid_tripped", 32'(bus.wdog_tripped), 32'd0);
    for (int k = 0; k < 15; k++) tick(3'b000, "idle_d");
    check("rst_cnt_zero", 32'(bus.safe_busy), 32'd0);
    tick(3'b000, "idle_d");
    check("rst_cnt_trip", 32'(bus.safe_busy), 32'd1);

    SYS_RST      = 1'b1;
    bus.wr_ready = 1'b0;
    tick(3'b000, "rst_end");
    sbq.delete();
    SYS_RST      = 1'b0;
    bus.wr_ready = 1'b1;

`ifdef SIDE_BUTTON_STOP_EN
    side_button = 1'b1;
    set_req(3'b010);
    tick(3'b000, "btn_edge");
    check("btn_busy", 32'(bus.safe_busy), 32'd1);
    push_safe();
    for (int k = 0; k < 5; k++) begin
      set_req(3'b010);
      tick(3'b000, "btn_safe");
    end
    check("btn_tripped", 32'(bus.wdog_tripped), 32'd1);
    set_req(3'b010);
    tick(3'b010, "btn_req1");
    set_req(3'b000);
    tick(3'b000, "btn_drain");
    check("btn_sb_drained", 32'(sbq.size()), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
